// File: rtl/instr_loader.sv
// instr_loader: loadable DEPTH x 6-bit instruction memory for the MCPU core.
// A bit-serial loader (ld_start / ser_stb+ser_dat / ld_end) fills the store;
// the CPU reads it combinationally through address -> instruction.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ld_start           pulse: begin (or restart) a load
//   ser_stb, ser_dat   bit strobe and serial data (words LSB first)
//   ld_end             pulse: terminate the load
//   busy               high while loading (LOAD/FIN); holds the core in reset
//   loaded             a valid program is present
//   err                sticky error from the last load
//   word_cnt           words written in the current/last load
//   address            CPU fetch address
//   instruction        fetched word, 6'h3F when no valid word is addressable
//
// Build option: define LOADER_CHECKSUM_EN to treat the last word of a load as
// a 6-bit modular checksum of the preceding words.
module instr_loader #(
  parameter int unsigned DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_start,
  input  logic       ser_stb,
  input  logic       ser_dat,
  input  logic       ld_end,
  output logic       busy,
  output logic       loaded,
  output logic       err,
  output logic [8:0] word_cnt,
  input  logic [7:0] address,
  output logic [5:0] instruction
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [8:0]  DEPTH_W = 9'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  state_t     state_q;
  logic [2:0] bitcnt_q;
  logic [4:0] shreg_q;
  logic [8:0] word_cnt_q;
  logic       busy_q;
  logic       loaded_q;
  logic       err_q;
  logic [5:0] mem [DEPTH];

  logic [5:0] word_w;
  logic       word_done;
  logic       wr_ok;
  logic       err_fin;
  logic [8:0] prog_len;
  logic       rd_ok;

`ifdef LOADER_CHECKSUM_EN
  logic [5:0] sum_q;
  logic [5:0] last_q;
`endif

  // Bit 5 is never stored in shreg_q: it arrives on the completing strobe.
  assign word_w    = {ser_dat, shreg_q};
  assign word_done = ser_stb && (bitcnt_q == 3'd5);
  assign wr_ok     = word_cnt_q < DEPTH_W;

  always_comb begin
    err_fin  = err_q;
    prog_len = word_cnt_q;
`ifdef LOADER_CHECKSUM_EN
    // sum_q covers every stored word including the checksum itself.
    if (word_cnt_q < 9'd2 || 6'(sum_q - last_q) != last_q) err_fin = 1'b1;
    if (word_cnt_q != '0) prog_len = word_cnt_q - 9'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
      last_q     <= '0;
`endif
    end else if (ld_start) begin
      state_q    <= LOAD;
      bitcnt_q   <= '0;
      word_cnt_q <= '0;
      busy_q     <= 1'b1;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
      last_q     <= '0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          if (ld_end) begin
            state_q  <= FIN;
            bitcnt_q <= '0;
            if (bitcnt_q != '0) err_q <= 1'b1;
          end else if (ser_stb) begin
            if (bitcnt_q == 3'd5) begin
              bitcnt_q <= '0;
              if (wr_ok) begin
                word_cnt_q <= word_cnt_q + 9'd1;
`ifdef LOADER_CHECKSUM_EN
                sum_q      <= sum_q + word_w;
                last_q     <= word_w;
`endif
              end else begin
                err_q <= 1'b1;
              end
            end else begin
              shreg_q[bitcnt_q] <= ser_dat;
              bitcnt_q          <= bitcnt_q + 3'd1;
            end
          end
        end
        FIN: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          err_q    <= err_fin;
          loaded_q <= !err_fin && (word_cnt_q != '0);
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; a write only happens in LOAD with no higher-priority pulse.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && !ld_start && !ld_end && word_done && wr_ok)
      mem[word_cnt_q[AW-1:0]] <= word_w;
  end

  assign rd_ok       = loaded_q && !busy_q && ({1'b0, address} < prog_len);
  assign instruction = rd_ok ? mem[address[AW-1:0]] : 6'h3F;

  assign busy     = busy_q;
  assign loaded   = loaded_q;
  assign err      = err_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_start, ser_stb, ser_dat, ld_end;
  logic [7:0] addr;
  logic       busy0, loaded0, err0, busy1, loaded1, err1;
  logic [8:0] cnt0, cnt1;
  logic [5:0] ins0, ins1;

  instr_loader #(.DEPTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ser_stb(ser_stb),
    .ser_dat(ser_dat), .ld_end(ld_end), .busy(busy0), .loaded(loaded0),
    .err(err0), .word_cnt(cnt0), .address(addr), .instruction(ins0)
  );

  instr_loader #(.DEPTH(4)) u_ovf (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ser_stb(ser_stb),
    .ser_dat(ser_dat), .ld_end(ld_end), .busy(busy1), .loaded(loaded1),
    .err(err1), .word_cnt(cnt1), .address(addr), .instruction(ins1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Transaction-level model: collected bits/words, per-instance results.
  int         D [2] = '{32, 4};
  int         phase;              // 0 idle, 1 loading, 2 finishing
  bit         m_busy;
  bit         m_loaded [2];
  bit         m_err [2];
  bit         m_bits [$];
  logic [5:0] m_words [$];
  logic [5:0] m_mem [2][32];

  task automatic check(string nm, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(int k);
    return (m_words.size() < D[k]) ? m_words.size() : D[k];
  endfunction

  function automatic int exp_len(int k);
    int n = exp_cnt(k);
`ifdef LOADER_CHECKSUM_EN
    if (n > 0) n = n - 1;
`endif
    return n;
  endfunction

  function automatic logic [5:0] exp_ins(int k);
    if (m_loaded[k] && !m_busy && int'(addr) < exp_len(k)) return m_mem[k][addr];
    return 6'h3F;
  endfunction

  task automatic model_reset();
    phase = 0; m_busy = 0;
    for (int k = 0; k < 2; k++) begin m_loaded[k] = 0; m_err[k] = 0; end
    m_bits.delete(); m_words.delete();
  endtask

  task automatic model_update(bit s, bit e, bit b, bit d);
    logic [5:0] w;
    if (s) begin
      phase = 1; m_busy = 1;
      for (int k = 0; k < 2; k++) begin m_loaded[k] = 0; m_err[k] = 0; end
      m_bits.delete(); m_words.delete();
    end else if (phase == 2) begin
      for (int k = 0; k < 2; k++) begin
        int n = exp_cnt(k);
        bit bad = 0;
`ifdef LOADER_CHECKSUM_EN
        if (n < 2) bad = 1;
        else begin
          int sum = 0;
          for (int i = 0; i < n - 1; i++) sum += int'(m_words[i]);
          if ((sum % 64) != int'(m_words[n-1])) bad = 1;
        end
`endif
        if (bad) m_err[k] = 1;
        m_loaded[k] = !m_err[k] && (n >= 1);
      end
      phase = 0; m_busy = 0;
    end else if (phase == 1) begin
      if (e) begin
        if (m_bits.size() != 0) for (int k = 0; k < 2; k++) m_err[k] = 1;
        m_bits.delete();
        phase = 2;
      end else if (b) begin
        m_bits.push_back(d);
        if (m_bits.size() == 6) begin
          for (int i = 0; i < 6; i++) w[i] = m_bits[i];
          for (int k = 0; k < 2; k++) begin
            if (m_words.size() < D[k]) m_mem[k][m_words.size()] = w;
            else m_err[k] = 1;
          end
          m_words.push_back(w);
          m_bits.delete();
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy32", busy0, m_busy);
      check("loaded32", loaded0, m_loaded[0]);
      check("err32", err0, m_err[0]);
      check("cnt32", cnt0, 9'(exp_cnt(0)));
      check("ins32", ins0, exp_ins(0));
      check("busy4", busy1, m_busy);
      check("loaded4", loaded1, m_loaded[1]);
      check("err4", err1, m_err[1]);
      check("cnt4", cnt1, 9'(exp_cnt(1)));
      check("ins4", ins1, exp_ins(1));
    end
  end

  // Called at posedge+2; returns at the next posedge+2.
  task automatic step(bit s, bit e, bit b, bit d);
    ld_start = s; ld_end = e; ser_stb = b; ser_dat = d;
    @(posedge clk);
    #1 model_update(s, e, b, d);
    #1 ld_start = 0; ld_end = 0; ser_stb = 0; ser_dat = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic send_word(logic [5:0] w);
    for (int i = 0; i < 6; i++) step(0, 0, 1, w[i]);
  endtask

  task automatic rd(logic [7:0] a, logic [5:0] exp);
    addr = a;
    #1 check("read", ins0, exp);
    idle(1);
  endtask

  initial begin
    rst_n = 1; ld_start = 0; ld_end = 0; ser_stb = 0; ser_dat = 0; addr = 0;
    model_reset();
    #1 rst_n = 0;
    #1;
    check("rst_busy", busy0, 0);
    check("rst_loaded", loaded0, 0);
    check("rst_err", err0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_ins", ins0, 6'h3F);
    @(posedge clk);
    #2 rst_n = 1;
    chk_on = 1;

    // ld_end / ser_stb ignored in IDLE
    step(0, 1, 1, 1); step(0, 0, 1, 1);

    // basic load
    step(1, 0, 0, 0);
    send_word(6'h12); send_word(6'h28); send_word(6'h3B);
`ifdef LOADER_CHECKSUM_EN
    send_word(6'h35);
`endif
    step(0, 1, 0, 0);
    idle(1);
    check("basic_busy", busy0, 0);
    check("basic_loaded", loaded0, 1);
    check("basic_err", err0, 0);
`ifdef LOADER_CHECKSUM_EN
    check("basic_cnt", cnt0, 4);
`else
    check("basic_cnt", cnt0, 3);
`endif
    rd(0, 6'h12); rd(1, 6'h28); rd(2, 6'h3B); rd(3, 6'h3F);

`ifdef LOADER_CHECKSUM_EN
    // bad checksum
    step(1, 0, 0, 0);
    send_word(6'h12); send_word(6'h28); send_word(6'h3B); send_word(6'h34);
    step(0, 1, 0, 0);
    idle(1);
    check("csum_err", err0, 1);
    check("csum_loaded", loaded0, 0);
    rd(0, 6'h3F); rd(1, 6'h3F); rd(2, 6'h3F); rd(3, 6'h3F);
`endif

    // partial word
    addr = 0;
    step(1, 0, 0, 0);
    send_word(6'h05);
    step(0, 0, 1, 1); step(0, 0, 1, 0); step(0, 0, 1, 1); step(0, 0, 1, 1);
    step(0, 1, 0, 0);
    idle(1);
    check("part_err", err0, 1);
    check("part_cnt", cnt0, 1);
    check("part_loaded", loaded0, 0);

    // overflow on the DEPTH=4 instance
    step(1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) send_word(6'(i));
    step(0, 1, 0, 0);
    idle(1);
    check("ovf_err", err1, 1);
    check("ovf_cnt", cnt1, 4);
    check("ovf_mem3", u_ovf.mem[3], 6'h04);
    check("ovf_model_mem3", m_mem[1][3], 6'h04);
`ifdef LOADER_CHECKSUM_EN
    check("ovf32_err", err0, 1);
`else
    check("ovf32_loaded", loaded0, 1);
    check("ovf32_cnt", cnt0, 5);
    rd(4, 6'h05);
`endif

    // ld_end together with the 6th strobe
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    idle(1);
    check("same_err", err0, 1);
    check("same_cnt", cnt0, 0);

    // restart in LOAD after two words
    step(1, 0, 0, 0);
    send_word(6'h0A); send_word(6'h0B);
    step(1, 0, 0, 0);
    check("restart_cnt", cnt0, 0);
    check("restart_busy", busy0, 1);
    send_word(6'h07);
    step(0, 1, 0, 0);
    idle(1);
`ifdef LOADER_CHECKSUM_EN
    check("restart_err", err0, 1);
`else
    check("restart_loaded", loaded0, 1);
    rd(0, 6'h07);
`endif

    // empty load: two busy cycles
    step(1, 0, 0, 0);
    check("empty_busy1", busy0, 1);
    step(0, 1, 0, 0);
    check("empty_busy2", busy0, 1);
    idle(1);
    check("empty_busy3", busy0, 0);
    check("empty_loaded", loaded0, 0);
`ifdef LOADER_CHECKSUM_EN
    check("empty_err", err0, 1);
`else
    check("empty_err", err0, 0);
`endif

    // reset mid-load, after a good program was present
    step(1, 0, 0, 0);
    send_word(6'h21); send_word(6'h22); step(0, 1, 0, 0); idle(1);
    addr = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, i[0]);
    rst_n = 0;
    #1;
    check("mrst_busy", busy0, 0);
    check("mrst_loaded", loaded0, 0);
    check("mrst_cnt", cnt0, 0);
    check("mrst_ins", ins0, 6'h3F);
    model_reset();
    #1 rst_n = 1;
    idle(2);

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
